pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/rv32i_pkg.sv | 26 ++
 rtl/hazard_detect.sv | 26 ++
 rtl/pipeline_ctrl.sv | 125 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I constants: opcodes used by the pipeline controller and the
// controller state encoding.
package rv32i_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Number of pipe_en cycles needed to flush the SYSTEM instruction out
    localparam int DRAIN_CYCLES = 3;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: decodes which source registers the ID
// instruction actually reads and compares them with a load in EX.
module hazard_detect
    import rv32i_pkg::*;
(
    input  logic [6:0] id_opcode,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    output logic       load_use
);

    logic rs1_use;
    logic rs2_use;

    // rs-use decode and compare; x0 is never a real dependency
    always_comb begin
        rs1_use  = !(id_opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
        rs2_use  = id_opcode inside {OP_OP, OP_STORE, OP_BRANCH};
        load_use = ex_mem_read && (ex_rd != 5'd0) &&
                   ((rs1_use && (ex_rd == id_rs1)) ||
                    (rs2_use && (ex_rd == id_rs2)));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: generates PC / pipeline-register enables,
// flush and bubble controls, counts load-use stalls and halts after a
// SYSTEM instruction has drained out of the pipeline.
module pipeline_ctrl
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  id_opcode,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic        imem_valid,
    input  logic        dmem_busy,
    output logic        pc_we,
    output logic        if_id_we,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        pipe_en,
    output logic        halted,
    output logic [15:0] stall_cnt
);

    state_t     state, state_next;
    logic [1:0] drain_cnt, drain_cnt_next;
    logic       load_use;
    logic       stall_inc;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    hazard_detect u_hazard (
        .id_opcode   (id_opcode),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    // Next-state and enable decode; rst forces every enable low
    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        stall_inc      = 1'b0;
        pc_we          = 1'b0;
        if_id_we       = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_bubble   = 1'b0;
        pipe_en        = 1'b0;
        case (state)
            ST_INIT: state_next = ST_RUN;
            ST_RUN: begin
                if (dmem_busy) begin
                    // whole pipeline holds
                end else if (ex_branch_taken) begin
                    pc_we        = 1'b1;
                    if_id_we     = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    pipe_en      = 1'b1;
                end else if (id_opcode == OP_SYSTEM) begin
                    // let the SYSTEM instruction advance, stop fetching
                    pipe_en        = 1'b1;
                    state_next     = ST_DRAIN;
                    drain_cnt_next = 2'd0;
                end else if (load_use) begin
                    id_ex_bubble = 1'b1;
                    pipe_en      = 1'b1;
                    stall_inc    = 1'b1;
                end else if (!imem_valid) begin
                    if_id_we    = 1'b1;
                    if_id_flush = 1'b1;
                    pipe_en     = 1'b1;
                end else begin
                    pc_we    = 1'b1;
                    if_id_we = 1'b1;
                    pipe_en  = 1'b1;
                end
            end
            ST_DRAIN: begin
                // IF/ID is frozen, so feed NOPs behind the draining instruction
                if (!dmem_busy) begin
                    pipe_en      = 1'b1;
                    id_ex_bubble = 1'b1;
                    if (drain_cnt == 2'(DRAIN_CYCLES - 1)) begin
                        state_next     = ST_HALTED;
                        drain_cnt_next = 2'd0;
                    end else begin
                        drain_cnt_next = drain_cnt + 2'd1;
                    end
                end
            end
            ST_HALTED: state_next = ST_HALTED;
            default:   state_next = ST_INIT;
        endcase
        if (rst) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_bubble = 1'b0;
            pipe_en      = 1'b0;
        end
    end

    // State, drain counter, stall counter and halted flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            drain_cnt <= 2'd0;
            stall_cnt <= 16'd0;
            halted    <= 1'b0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
            halted    <= (state_next == ST_HALTED);
            if (stall_inc)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: the driver applies one cycle of
// inputs, a reference model predicts that cycle's outputs and queues them,
// and a monitor compares the DUT outputs mid-cycle against the queue.
module tb_pipeline_ctrl;

    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] OPR    = 7'b0110011;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    localparam int M_INIT = 0, M_RUN = 1, M_DRAIN = 2, M_HALT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  id_opcode = OPIMM;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic        ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
    logic        imem_valid = 1'b1, dmem_busy = 1'b0;
    logic        pc_we, if_id_we, if_id_flush, id_ex_bubble, pipe_en, halted;
    logic [15:0] stall_cnt;

    typedef struct {
        int          idx;
        logic        pc_we, if_id_we, if_id_flush, id_ex_bubble, pipe_en, halted;
        logic [15:0] stall_cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;

    // reference model state
    int          m_mode = M_INIT;
    int          m_drain_left = 0;
    int unsigned m_stalls = 0;
    logic        m_halted = 1'b0;

    pipeline_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .id_opcode       (id_opcode),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .imem_valid      (imem_valid),
        .dmem_busy       (dmem_busy),
        .pc_we           (pc_we),
        .if_id_we        (if_id_we),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .pipe_en         (pipe_en),
        .halted          (halted),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, idx, act, exp);
        end
    endtask

    // An instruction depends on a load in EX if it reads that register
    function automatic bit depends(input logic [6:0] op, input logic [4:0] r1,
                                   input logic [4:0] r2, input logic [4:0] rd,
                                   input logic mr);
        bit reads1, reads2;
        reads1 = !(op == LUI || op == AUIPC || op == JAL);
        reads2 = (op == OPR || op == STORE || op == BRANCH);
        if (!mr || rd == 0) return 0;
        return (reads1 && r1 == rd) || (reads2 && r2 == rd);
    endfunction

    // Apply one cycle of inputs, predict outputs, advance the model
    task automatic step(input logic r, input logic [6:0] op, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd, input logic mr,
                        input logic br, input logic iv, input logic bz);
        exp_t e;
        bit   hz;
        @(posedge clk);
        #1;
        rst = r; id_opcode = op; id_rs1 = r1; id_rs2 = r2; ex_rd = rd;
        ex_mem_read = mr; ex_branch_taken = br; imem_valid = iv; dmem_busy = bz;
        #1;
        hz = depends(op, r1, r2, rd, mr);
        e.idx = cycle; e.pc_we = 0; e.if_id_we = 0; e.if_id_flush = 0;
        e.id_ex_bubble = 0; e.pipe_en = 0;
        e.halted = m_halted; e.stall_cnt = 16'(m_stalls);
        if (!r && m_mode == M_RUN && !bz) begin
            if (br) begin
                e.pc_we = 1; e.if_id_we = 1; e.if_id_flush = 1; e.id_ex_bubble = 1; e.pipe_en = 1;
            end else if (op == SYSTEM) begin
                e.pipe_en = 1;
            end else if (hz) begin
                e.id_ex_bubble = 1; e.pipe_en = 1;
            end else if (!iv) begin
                e.if_id_we = 1; e.if_id_flush = 1; e.pipe_en = 1;
            end else begin
                e.pc_we = 1; e.if_id_we = 1; e.pipe_en = 1;
            end
        end else if (!r && m_mode == M_DRAIN && !bz) begin
            e.pipe_en = 1; e.id_ex_bubble = 1;
        end
        q.push_back(e);
        cycle++;
        if (r) begin
            m_mode = M_INIT; m_stalls = 0; m_halted = 0; m_drain_left = 0;
        end else if (m_mode == M_INIT) begin
            m_mode = M_RUN;
        end else if (m_mode == M_RUN && !bz && !br) begin
            if (op == SYSTEM) begin
                m_mode = M_DRAIN; m_drain_left = 3;
            end else if (hz && m_stalls < 65535) begin
                m_stalls++;
            end
        end else if (m_mode == M_DRAIN && !bz) begin
            m_drain_left--;
            if (m_drain_left == 0) begin
                m_mode = M_HALT; m_halted = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, OPIMM, 5'd1, 5'd2, 5'd0, 0, 0, 1, 0);
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc_we",        e.idx, int'(pc_we),        int'(e.pc_we));
                chk("if_id_we",     e.idx, int'(if_id_we),     int'(e.if_id_we));
                chk("if_id_flush",  e.idx, int'(if_id_flush),  int'(e.if_id_flush));
                chk("id_ex_bubble", e.idx, int'(id_ex_bubble), int'(e.id_ex_bubble));
                chk("pipe_en",      e.idx, int'(pipe_en),      int'(e.pipe_en));
                chk("halted",       e.idx, int'(halted),       int'(e.halted));
                chk("stall_cnt",    e.idx, int'(stall_cnt),    int'(e.stall_cnt));
            end
        end
    end

    initial begin
        int wait_cycles;
        logic [6:0] ops[10];
        ops = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OPR, SYSTEM};

        // reset and INIT cycle
        step(1, OPIMM, 0, 0, 0, 0, 0, 1, 0);
        step(1, OPIMM, 0, 0, 0, 0, 0, 1, 0);
        idle(2);

        // load-use: ADD r4,r3,r2 behind a load to r3, then the load moves on
        step(0, OPR, 5'd3, 5'd2, 5'd3, 1, 0, 1, 0);
        step(0, OPR, 5'd3, 5'd2, 5'd3, 0, 0, 1, 0);
        // rs2 dependency through a store
        step(0, STORE, 5'd5, 5'd7, 5'd7, 1, 0, 1, 0);
        idle(1);

        // no stall: load to x0, and LUI whose rs1 field happens to match
        step(0, OPR, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0);
        step(0, LUI, 5'd3, 5'd0, 5'd3, 1, 0, 1, 0);
        step(0, OPIMM, 5'd1, 5'd3, 5'd3, 1, 0, 1, 0);

        // branch together with a load-use hazard
        step(0, OPR, 5'd3, 5'd2, 5'd3, 1, 1, 1, 0);
        idle(1);

        // dmem_busy for two cycles during a hazard, then the stall cycle
        step(0, OPR, 5'd3, 5'd2, 5'd3, 1, 0, 1, 1);
        step(0, OPR, 5'd3, 5'd2, 5'd3, 1, 1, 1, 1);
        step(0, OPR, 5'd3, 5'd2, 5'd3, 1, 0, 1, 0);
        step(0, OPR, 5'd3, 5'd2, 5'd3, 0, 0, 1, 0);

        // fetch miss
        step(0, OPIMM, 5'd1, 5'd2, 5'd0, 0, 0, 0, 0);
        idle(1);

        // ECALL: drain with one busy cycle and an ignored branch, then halt
        step(0, SYSTEM, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
        step(0, OPIMM, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0);
        step(0, OPIMM, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1);
        idle(2);
        idle(10);

        // leave HALTED by reset, then reset in the middle of a drain
        step(1, OPIMM, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        step(0, OPR, 5'd3, 5'd2, 5'd3, 1, 0, 1, 0);
        step(0, SYSTEM, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
        idle(1);
        step(1, OPIMM, 0, 0, 0, 0, 0, 1, 0);
        idle(3);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [6:0] op;
            op = ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 29) == 0) op = SYSTEM;
            if ($urandom_range(0, 19) == 0) op = 7'($urandom);
            step(($urandom_range(0, 24) == 0), op,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 5) == 0));
        end

        // let the monitor empty the queue, with a bound
        wait_cycles = 0;
        while (q.size() > 0 && wait_cycles < 10) begin
            @(negedge clk);
            #1;
            wait_cycles++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain_queue left=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
